// File: rtl/multdiv_pkg.sv
// multdiv_pkg: state encoding and op codes shared by the iterative multiply/divide unit
package multdiv_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/multdiv_iter_div_step.sv
// div_step: one restoring subtract/shift of an unsigned divide, one quotient bit per call
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0] sh, diff;
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, div};
  assign rem_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed Booth multiply / restoring divide, one result bit per cycle
// Divider is compiled in only when MULTDIV_DIVIDE_EN is defined.
module multdiv_iter import multdiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, step_acc;
  logic [WIDTH-1:0] m_q, m_d, result_q, result_d, fin_res;
  logic op_q, op_d, exc_q, exc_d, fin_exc, last, mul_ovf;
  logic [WIDTH:0] hi_ext, bsum;
  logic [2*WIDTH-1:0] prod;
  // Booth add is done one bit wider so the shifted-in sign survives a MIN operand
  assign hi_ext = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
  assign bsum = acc_q[1:0] == 2'b01 ? hi_ext + {m_q[WIDTH-1], m_q} :
                acc_q[1:0] == 2'b10 ? hi_ext - {m_q[WIDTH-1], m_q} : hi_ext;
  assign prod = acc_q[AW-1:1];
  assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
  assign last = cnt_q == CW'(WIDTH - 1);
`ifdef MULTDIV_DIVIDE_EN
  logic neg_q, neg_d;
  logic [WIDTH-1:0] rem_n, quo_n, quo, a_mag, b_mag;
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem   (acc_q[2*WIDTH-1:WIDTH]),
    .quo   (acc_q[WIDTH-1:0]),
    .div   (m_q),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );
  assign quo = acc_q[WIDTH-1:0];
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign step_acc = op_q == OP_MULT ? {bsum, acc_q[WIDTH:1]} : {1'b0, rem_n, quo_n};
  // Only MIN / -1 yields a positive quotient with its top bit set
  assign fin_res = op_q == OP_MULT ? prod[WIDTH-1:0] : m_q == '0 ? '0 : neg_q ? -quo : quo;
  assign fin_exc = op_q == OP_MULT ? mul_ovf : (m_q == '0) | (!neg_q & quo[WIDTH-1]);
`else
  assign step_acc = {bsum, acc_q[WIDTH:1]};
  assign fin_res = op_q == OP_MULT ? prod[WIDTH-1:0] : '0;
  assign fin_exc = op_q == OP_MULT ? mul_ovf : 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    op_d = op_q;
    result_d = result_q;
    exc_d = exc_q;
`ifdef MULTDIV_DIVIDE_EN
    neg_d = neg_q;
`endif
    if (state_q == DONE) begin
      result_d = fin_res;
      exc_d = fin_exc;
      state_d = IDLE;
    end
    if (state_q == RUN) begin
      acc_d = step_acc;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? DONE : RUN;
    end
    if (ctrl_MULT | ctrl_DIV) begin
      cnt_d = '0;
      op_d = ctrl_MULT ? OP_MULT : OP_DIV;
      state_d = RUN;
      if (ctrl_MULT) begin
        acc_d = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        m_d = data_operandA;
      end else begin
`ifdef MULTDIV_DIVIDE_EN
        acc_d = {{(WIDTH+1){1'b0}}, a_mag};
        m_d = b_mag;
        neg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`else
        state_d = DONE;
`endif
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      op_q <= OP_MULT;
      result_q <= '0;
      exc_q <= 1'b0;
`ifdef MULTDIV_DIVIDE_EN
      neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      op_q <= op_d;
      result_q <= result_d;
      exc_q <= exc_d;
`ifdef MULTDIV_DIVIDE_EN
      neg_q <= neg_d;
`endif
    end
  end
  assign data_result = state_q == DONE ? fin_res : result_q;
  assign data_exception = state_q == DONE ? fin_exc : exc_q;
  assign data_resultRDY = state_q == DONE;
  assign busy = state_q == RUN;
endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: directed vectors for multdiv_iter at WIDTH=32; divide expectations follow MULTDIV_DIVIDE_EN
module tb_multdiv_iter;
`ifdef MULTDIV_DIVIDE_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY, busy;
  int n_checks = 0;
  int n_fail = 0;
  multdiv_iter #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee,
                        input int eedges, input int ebusy);
    int edges, busy_n;
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = ~a;
    data_operandB = ~b;
    edges = 1;
    busy_n = int'(busy);
    while (!data_resultRDY && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
      busy_n += int'(busy);
    end
    check({tag, " edges"}, 64'(edges), 64'(eedges));
    check({tag, " result"}, 64'(data_result), 64'(er));
    check({tag, " exc"}, 64'(data_exception), 64'(ee));
    check({tag, " busy"}, 64'(busy_n), 64'(ebusy));
    @(posedge clock);
    #1;
    check({tag, " rdy_drop"}, 64'(data_resultRDY), 64'(0));
    check({tag, " hold"}, 64'(data_result), 64'(er));
  endtask
  initial begin
    int strobes, at_edge, edges;
    logic [31:0] res;
    logic exc;
    repeat (3) @(posedge clock);
    #1;
    check("rst result", 64'(data_result), 64'(0));
    check("rst exc", 64'(data_exception), 64'(0));
    check("rst rdy", 64'(data_resultRDY), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    run_op("mul 7x-3", 1, 0, 32'd7, -32'sd3, -32'sd21, 0, 33, 32);
    run_op("mul 2^16sq", 1, 0, 32'd65536, 32'd65536, 32'd0, 1, 33, 32);
    run_op("mul MINx1", 1, 0, MIN, 32'd1, MIN, 0, 33, 32);
    run_op("div -7/2", 0, 1, -32'sd7, 32'd2, DE ? -32'sd3 : 32'd0, !DE, DE ? 33 : 1, DE ? 32 : 0);
    run_op("div 5/0", 0, 1, 32'd5, 32'd0, 32'd0, 1, DE ? 33 : 1, DE ? 32 : 0);
    run_op("div MIN/-1", 0, 1, MIN, -32'sd1, DE ? MIN : 32'd0, 1, DE ? 33 : 1, DE ? 32 : 0);
    run_op("both 6,3", 1, 1, 32'd6, 32'd3, 32'd18, 0, 33, 32);
    // Abort a multiply in its tenth RUN cycle with a divide
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    strobes = 0;
    at_edge = 0;
    res = '1;
    exc = 1'bx;
    repeat (9) begin
      @(posedge clock);
      #1;
      strobes += int'(data_resultRDY);
    end
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    edges = 1;
    if (data_resultRDY) begin
      strobes++;
      at_edge = edges;
      res = data_result;
      exc = data_exception;
    end
    repeat (40) begin
      @(posedge clock);
      #1;
      edges++;
      if (data_resultRDY) begin
        strobes++;
        at_edge = edges;
        res = data_result;
        exc = data_exception;
      end
    end
    check("abort strobes", 64'(strobes), 64'(1));
    check("abort edge", 64'(at_edge), 64'(DE ? 33 : 1));
    check("abort result", 64'(res), 64'(DE ? 32'd3 : 32'd0));
    check("abort exc", 64'(exc), 64'(!DE));
    // Reset in the fifth RUN cycle
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midrst result", 64'(data_result), 64'(0));
    check("midrst exc", 64'(data_exception), 64'(0));
    check("midrst rdy", 64'(data_resultRDY), 64'(0));
    check("midrst busy", 64'(busy), 64'(0));
    @(negedge clock);
    ctrl_MULT = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    check("rst ignores start", 64'(busy), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      strobes += int'(data_resultRDY) + int'(busy);
    end
    check("no strobe after rst", 64'(strobes), 64'(0));
    check("post rst result", 64'(data_result), 64'(0));
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    run_op("mul 4x4", 1, 0, 32'd4, 32'd4, 32'd16, 0, 33, 32);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 The parameter list SHALL be: WIDTH, 32, operand and result width in bits; legal values are 4 to 64.
REQ-002 The port list SHALL be: clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The port list SHALL include: reset, input, 1, asynchronous active-low reset.
REQ-004 The port list SHALL include: data_operandA, input, WIDTH, signed multiplicand or dividend.
REQ-005 The port list SHALL include: data_operandB, input, WIDTH, signed multiplier or divisor.
REQ-006 The port list SHALL include: ctrl_MULT, input, 1, one-cycle start pulse for a multiply.
REQ-007 The port list SHALL include: ctrl_DIV, input, 1, one-cycle start pulse for a divide.
REQ-008 The port list SHALL include: data_result, output, WIDTH, product low word or quotient.
REQ-009 The port list SHALL include: data_exception, output, 1, error flag, valid while data_resultRDY=1.
REQ-010 The port list SHALL include: data_resultRDY, output, 1, one-cycle completion strobe.
REQ-011 The port list SHALL include: busy, output, 1, high while an operation is in flight; the processor stalls on it.

Function
REQ-012 The unit SHALL use three states: IDLE, RUN, DONE.
REQ-013 On any edge with ctrl_MULT or ctrl_DIV high, the unit SHALL latch both operands and the op, clear its step counter, and enter RUN.
REQ-014 The unit SHALL compute one result bit per cycle in RUN and leave RUN after exactly WIDTH cycles.
REQ-015 Multiply SHALL be radix-2 Booth on a 2*WIDTH+1 bit accumulator.
REQ-016 Divide SHALL be restoring division on operand magnitudes, with the sign fixed in DONE.
REQ-017 DONE SHALL last one cycle; data_resultRDY=1 only in DONE; the next state is IDLE.
REQ-018 Latency SHALL be fixed: data_resultRDY is high in the cycle that begins WIDTH+1 edges after the start edge.
REQ-019 busy SHALL be high in RUN and low in IDLE and DONE.
REQ-020 data_result SHALL hold its last value in IDLE until the next DONE.
REQ-021 Operands SHALL be sampled only on the start edge; input changes during RUN have no effect.
REQ-022 Arithmetic SHALL be two's complement; data_result is the low WIDTH bits of the product.
REQ-023 Multiply SHALL set exception when the full product does not fit a signed WIDTH-bit value.
REQ-024 Quotient SHALL truncate toward zero; the remainder is discarded.
REQ-025 Divide by zero SHALL give exception=1 and result=0; RUN still lasts WIDTH cycles.
REQ-026 Divide of MIN by -1 SHALL give exception=1 and result=MIN.
REQ-027 If ctrl_MULT and ctrl_DIV are high on the same edge, the unit SHALL perform the multiply.
REQ-028 A start in RUN or DONE SHALL abort the current op with no strobe for it and restart per REQ-013.

Reset
REQ-029 While reset=0 (asynchronous), the unit SHALL hold: state=IDLE; data_result=0; data_exception=0; data_resultRDY=0; busy=0; counter and accumulators=0.
REQ-030 A reset mid-operation SHALL discard the operation with no strobe.
REQ-031 Start pulses SHALL be ignored while reset=0.
REQ-032 After reset releases, start pulses SHALL be honoured from the first rising edge.

Configuration
REQ-033 The macro MULTDIV_DIVIDE_EN SHALL compile the divider in when defined.
REQ-034 When MULTDIV_DIVIDE_EN is defined, ctrl_DIV SHALL behave per REQ-016 and REQ-024 to REQ-026.
REQ-035 When MULTDIV_DIVIDE_EN is undefined, the divide datapath SHALL be absent.
REQ-036 When MULTDIV_DIVIDE_EN is undefined, ctrl_DIV alone SHALL produce DONE on the next edge with result=0 and exception=1; busy stays low.

Structure
REQ-037 The shared package multdiv_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the op-code constants OP_MULT and OP_DIV.
REQ-038 The counter width SHALL be derived from WIDTH.
REQ-039 The sub-module div_step SHALL perform one restoring subtract/shift per cycle and be instantiated only under MULTDIV_DIVIDE_EN.
REQ-040 The unit SHALL instantiate no other sub-modules.

Verification
REQ-041 The bench SHALL cover, at WIDTH=32 and all values in decimal: MULT 7 x -3 -> result=-21, exception=0, strobe on edge 33 after start, busy high for 32 cycles.
REQ-042 The bench SHALL cover: MULT 65536 x 65536 -> result=0, exception=1; MULT -2147483648 x 1 -> result=-2147483648, exception=0.
REQ-043 The bench SHALL cover: DIV -7 / 2 -> result=-3, exception=0; DIV 5 / 0 -> result=0, exception=1; DIV -2147483648 / -1 -> result=-2147483648, exception=1.
REQ-044 The bench SHALL cover: ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result=18.
REQ-045 The bench SHALL cover: MULT 2 x 3 started, ctrl_DIV 9/3 at RUN cycle 10 -> exactly one strobe, result=3, 33 edges after the second start.
REQ-046 The bench SHALL cover: reset=0 at RUN cycle 5 -> all outputs 0 immediately; no strobe after release; a new MULT 4 x 4 then gives 16.
